// File: rtl/neuron_layer_ctrl.sv
// neuron_layer_ctrl: issues one neuron per cycle to a pipelined datapath and tags results back to their index.
module neuron_layer_ctrl #(
  parameter int LATENCY = 7,
  parameter int ADDR_W = 8,
  parameter int VEC_W = 238
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VEC_W-1:0]  x_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [VEC_W-1:0]  w_data,
  output logic [VEC_W-1:0]  nx,
  output logic [VEC_W-1:0]  nw,
  output logic              nce,
  input  logic [16:0]       ny,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_idx,
  output logic [16:0]       res_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] k, base, cnt;
  // stage 0 lines up with nw, stage LATENCY with ny
  logic [LATENCY:0] tv;
  logic [ADDR_W-1:0] ti [LATENCY+1];
  assign busy = state != IDLE;
  assign nce = busy;
  assign done = state == DONE;
  assign w_rd = state == ISSUE;
  assign w_addr = w_rd ? base + k : '0;
  assign nw = w_data;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? (count == '0 ? DONE : ISSUE) : IDLE;
      ISSUE: state_n = k == cnt - 1'b1 ? DRAIN : ISSUE;
      DRAIN: state_n = tv == '0 ? DONE : DRAIN;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      base <= '0;
      cnt <= '0;
      nx <= '0;
      tv <= '0;
      res_valid <= 1'b0;
      res_idx <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        nx <= x_in;
        base <= base_addr;
        cnt <= count;
        k <= '0;
      end else if (w_rd) k <= k + 1'b1;
      tv <= {tv[LATENCY-1:0], w_rd};
      res_valid <= tv[LATENCY];
      if (tv[LATENCY]) begin
        res_idx <= ti[LATENCY];
        res_data <= ny;
      end
    end
  end
  always_ff @(posedge clk) begin
    ti[0] <= k;
    for (int i = 1; i <= LATENCY; i++) ti[i] <= ti[i-1];
  end
endmodule
